// File: rtl/clk_div_pkg.sv
// Shared types and ratio rules for the clock-divider scheduler.
// Define CLK_DIV_ODD_EN to accept odd ratios (high phase one cycle longer).
package clk_div_pkg;

    localparam int unsigned CW_DEF = 8;

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    function automatic logic ratio_ok(input int unsigned div);
`ifdef CLK_DIV_ODD_EN
        return div >= 2;
`else
        return (div >= 2) && ((div % 2) == 0);
`endif
    endfunction

    function automatic int unsigned half_hi(input int unsigned div);
`ifdef CLK_DIV_ODD_EN
        return (div + 1) / 2;
`else
        return div / 2;
`endif
    endfunction

    function automatic int unsigned half_lo(input int unsigned div);
        return div / 2;
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// Phase counter and registered clk_out toggle; flags the last low cycle of a period.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int unsigned CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_load,
    input  logic          i_en,
    input  logic [CW-1:0] i_div,
    output logic          o_clk,
    output logic          o_bnd
);

    logic          r_clk;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_hi_last;
    logic [CW-1:0] w_lo_last;

    assign w_hi_last = CW'(half_hi(32'(i_div)) - 1);
    assign w_lo_last = CW'(half_lo(32'(i_div)) - 1);
    assign o_bnd     = !r_clk && (r_cnt == w_lo_last);
    assign o_clk     = r_clk;

    // load starts a fresh period; disabling parks the waveform low at count zero
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_clk <= 1'b0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_clk <= 1'b1;
            r_cnt <= '0;
        end else if (!i_en) begin
            r_clk <= 1'b0;
            r_cnt <= '0;
        end else if (r_clk && (r_cnt == w_hi_last)) begin
            r_clk <= 1'b0;
            r_cnt <= '0;
        end else if (!r_clk && (r_cnt == w_lo_last)) begin
            r_clk <= 1'b1;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clk_div_sched.sv
// Runtime-reconfigurable clock divider: ratio handshake, boundary-aligned updates, start/stop.
// Odd-ratio support is enabled by defining CLK_DIV_ODD_EN.
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int unsigned CW      = CW_DEF,
    parameter int unsigned DEF_DIV = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          run,
    input  logic          cfg_valid,
    input  logic [CW-1:0] cfg_div,
    output logic          cfg_ready,
    output logic          cfg_err,
    output logic          clk_out,
    output logic          tick,
    output logic [CW-1:0] active_div,
    output logic          busy
);

    state_t        r_state;
    logic [CW-1:0] r_active;
    logic [CW-1:0] r_pend;
    logic          r_tick;
    logic          r_err;
    logic          w_bnd;
    logic          w_load;
    logic          w_en;
    logic          w_acc;
    logic          w_ok;

    assign cfg_ready  = (r_state != PEND);
    assign w_acc      = cfg_valid && cfg_ready;
    assign w_ok       = ratio_ok(32'(cfg_div));
    assign cfg_err    = r_err;
    assign tick       = r_tick;
    assign active_div = r_active;
    assign busy       = (r_state != IDLE);

    // at a boundary the core either restarts a period (load) or is parked (stop)
    always_comb begin
        w_load = 1'b0;
        w_en   = (r_state != IDLE);
        case (r_state)
            IDLE: w_load = run;
            RUN, PEND: begin
                if (w_bnd) begin
                    if (run) w_load = 1'b1;
                    else     w_en   = 1'b0;
                end
            end
            default: w_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_active <= CW'(DEF_DIV);
            r_pend   <= '0;
            r_tick   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_tick <= w_load;
            r_err  <= w_acc && !w_ok;
            case (r_state)
                IDLE: begin
                    if (w_acc && w_ok) r_active <= cfg_div;
                    if (run)           r_state  <= RUN;
                end
                RUN: begin
                    // a ratio accepted on a stopping boundary is loaded directly
                    if (w_bnd && !run) begin
                        r_state <= IDLE;
                        if (w_acc && w_ok) r_active <= cfg_div;
                    end else if (w_acc && w_ok) begin
                        r_pend  <= cfg_div;
                        r_state <= PEND;
                    end
                end
                PEND: begin
                    if (w_bnd) begin
                        r_active <= r_pend;
                        r_state  <= run ? RUN : IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    clk_div_core #(.CW(CW)) u_core (
        .clk    (clk),
        .rstn   (rstn),
        .i_load (w_load),
        .i_en   (w_en),
        .i_div  (r_active),
        .o_clk  (clk_out),
        .o_bnd  (w_bnd)
    );

endmodule

// File: tb/tb_clk_div_sched.sv
// Scoreboard bench: a period-position reference model predicts every cycle's outputs.
module tb_clk_div_sched;

    localparam int unsigned CW      = 8;
    localparam int unsigned DEF_DIV = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          run;
    logic          cfg_valid;
    logic [CW-1:0] cfg_div;
    logic          cfg_ready;
    logic          cfg_err;
    logic          clk_out;
    logic          tick;
    logic [CW-1:0] active_div;
    logic          busy;

    clk_div_sched #(.CW(CW), .DEF_DIV(DEF_DIV)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .run        (run),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .clk_out    (clk_out),
        .tick       (tick),
        .active_div (active_div),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          clk_out;
        logic          tick;
        logic          busy;
        logic          ready;
        logic          err;
        logic [CW-1:0] div;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // reference state: position within the current period, not phase counters
    int unsigned m_div    = DEF_DIV;
    int unsigned m_p      = 0;
    int unsigned m_pend   = 0;
    bit          m_busy   = 0;
    bit          m_pend_v = 0;
    bit          m_tick   = 0;
    bit          m_err    = 0;

    function automatic int unsigned hi_len(input int unsigned d);
`ifdef CLK_DIV_ODD_EN
        return (d + 1) / 2;
`else
        return d / 2;
`endif
    endfunction

    function automatic bit legal(input int unsigned d);
`ifdef CLK_DIV_ODD_EN
        return d >= 2;
`else
        return (d >= 2) && (d % 2 == 0);
`endif
    endfunction

    task automatic model_step();
        bit   acc, ok, bnd;
        exp_t e;
        if (!rstn) begin
            m_div = DEF_DIV; m_p = 0; m_pend = 0;
            m_busy = 0; m_pend_v = 0; m_tick = 0; m_err = 0;
        end else begin
            acc    = cfg_valid && !m_pend_v;
            ok     = legal(int'(cfg_div));
            m_err  = acc && !ok;
            m_tick = 0;
            if (!m_busy) begin
                if (acc && ok) m_div = cfg_div;
                if (run) begin
                    m_busy = 1; m_p = 0; m_tick = 1;
                end
            end else begin
                bnd = (m_p == m_div - 1);
                if (bnd) begin
                    if (m_pend_v) begin
                        m_div = m_pend; m_pend_v = 0;
                    end else if (acc && ok) begin
                        if (run) begin
                            m_pend = cfg_div; m_pend_v = 1;
                        end else begin
                            m_div = cfg_div;
                        end
                    end
                    if (run) begin
                        m_p = 0; m_tick = 1;
                    end else begin
                        m_busy = 0; m_p = 0;
                    end
                end else begin
                    m_p++;
                    if (acc && ok) begin
                        m_pend = cfg_div; m_pend_v = 1;
                    end
                end
            end
        end
        e.clk_out = m_busy && (m_p < hi_len(m_div));
        e.tick    = m_tick;
        e.busy    = m_busy;
        e.ready   = !m_pend_v;
        e.err     = m_err;
        e.div     = CW'(m_div);
        exp_q.push_back(e);
    endtask

    initial begin : model
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty cyc%0d: no expected entry available", cyc);
            end else begin
                e = exp_q.pop_front();
                if (clk_out !== e.clk_out || tick !== e.tick || busy !== e.busy ||
                    cfg_ready !== e.ready || cfg_err !== e.err || active_div !== e.div) begin
                    n_fail++;
                    $display("FAIL outputs cyc%0d: got clk_out=%b tick=%b busy=%b ready=%b err=%b div=%0d, expected clk_out=%b tick=%b busy=%b ready=%b err=%b div=%0d",
                             cyc, clk_out, tick, busy, cfg_ready, cfg_err, active_div,
                             e.clk_out, e.tick, e.busy, e.ready, e.err, e.div);
                end
            end
        end
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic offer(input int unsigned d);
        cfg_valid = 1'b1;
        cfg_div   = CW'(d);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin : stimulus
        rstn = 1'b0; run = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        idle_cycles(3);
        rstn = 1'b1;
        idle_cycles(2);
        run = 1'b1;
        idle_cycles(18);
        offer(4);                 // mid-period ratio change
        idle_cycles(30);
        offer(5);
        idle_cycles(3);
        offer(0);
        idle_cycles(20);
        idle_cycles(1);
        run = 1'b0;               // stop request
        idle_cycles(20);
        run = 1'b1;               // start and configure in the same cycle
        offer(6);
        idle_cycles(20);
        offer(2);
        idle_cycles(10);
        offer(4);                 // reset while a ratio is pending
        idle_cycles(1);
        rstn = 1'b0;
        idle_cycles(1);
        rstn = 1'b1;
        idle_cycles(20);
        for (int i = 0; i < 4000; i++) begin
            rstn      = ($urandom % 300) != 0;
            if (($urandom % 40) == 0) run = ~run;
            cfg_valid = ($urandom % 4) == 0;
            cfg_div   = (($urandom % 10) == 0) ? CW'($urandom % 256) : CW'($urandom % 21);
            @(negedge clk);
        end
        rstn = 1'b1; run = 1'b0; cfg_valid = 1'b0;
        idle_cycles(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_sched.md
Name: clk_div_sched

Overview:
Runtime-reconfigurable clock-divider controller. It generates a divided clock-enable waveform from clk and accepts new divide ratios through a valid/ready handshake. New ratios are applied only at a period boundary, so clk_out never emits a runt or stretched phase. It also sequences clean start and stop of the divided output, and sits between the register/config interface and downstream logic that is clocked or enabled by the divided waveform.

Parameters:
CW, 8, width of divide ratio and internal counter
DEF_DIV, 8, divide ratio loaded at reset; must be even and >=2

Ports:
clk  in  1  system clock
rstn  in  1  reset; synchronous, active-low
run  in  1  level; 1 = generate divided clock, 0 = stop at next period boundary
cfg_valid  in  1  new divide ratio offered
cfg_div  in  CW  requested divide ratio
cfg_ready  out  1  controller can accept cfg_div this cycle
cfg_err  out  1  one-cycle pulse: offered ratio rejected
clk_out  out  1  registered divided waveform
tick  out  1  one-cycle pulse in the first high cycle of every clk_out period
active_div  out  CW  ratio currently in effect
busy  out  1  1 when state != IDLE

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE, clk_out=0, tick=0, cfg_err=0, cnt=0, active_div=DEF_DIV, pending ratio cleared.
- Ratio check: a ratio is valid if it is even and >=2. Otherwise the handshake still completes (cfg_ready=1), cfg_err pulses the following cycle, and all state is unchanged.
- Phases: high phase length H_hi = active_div/2 cycles, low phase length H_lo = active_div/2 cycles. cnt counts 0..H-1 within the current phase; at H-1 the phase flips and cnt returns to 0.
- Period boundary: the cycle with clk_out=0 and cnt==H_lo-1, i.e. the cycle where the next edge would be a rise.
- FSM states: IDLE, RUN, PEND.
- IDLE:
  - clk_out=0; cfg_ready=1; a valid cfg loads active_div on the next cycle.
  - run=1 makes the next cycle clk_out=1, tick=1, cnt=0, state RUN.
  - If run=1 and a valid cfg arrive in the same cycle, the new ratio is used for the first period.
- RUN:
  - cfg_ready=1. Accepting a valid cfg stores it as pending and moves to PEND. A cfg accepted on a boundary cycle is applied at the following boundary, not the current one.
  - At a boundary with run=1: clk_out rises, tick=1.
  - At a boundary with run=0: clk_out stays 0, go to IDLE. Stopping therefore always completes the full low phase.
- PEND:
  - cfg_ready=0.
  - At the boundary, active_div takes the pending ratio and the new period starts with the new ratio.
  - If run=1: rise and tick, go to RUN. If run=0: go to IDLE with the new ratio loaded.
- tick and clk_out are registered; tick coincides with the first cycle of clk_out=1.
- Minimum ratio 2 gives clk_out toggling every cycle.
- cnt is CW bits wide; ratios up to 2^CW-2 are supported with no wrap.
- rstn=0 mid-period overrides everything: clk_out=0 on the next cycle, any pending ratio is discarded.

Optional Feature:
CLK_DIV_ODD_EN
- Defined: odd ratios >=3 are valid. H_hi = (div+1)/2, H_lo = div/2, so duty cycle is high-biased by one cycle. All logic stays on posedge clk.
- Undefined: odd ratios are rejected with cfg_err and H_hi = H_lo = div/2.

Decomposition:
- Shared package clk_div_pkg holds: state enum {IDLE, RUN, PEND}, CW default, and the ratio-valid function. The valid function's odd acceptance is governed by the CLK_DIV_ODD_EN macro.
- One sub-module, clk_div_core, holds the phase counter and clk_out toggle. Its inputs are a load strobe, ratio, enable and boundary output. clk_div_sched owns the FSM and the handshake.

Test Plan:
1. Reset, then run=1 with DEF_DIV=8: clk_out gives 4 high/4 low cycles; tick every 8 cycles starting the cycle after run; active_div=8.
2. While running at 8, offer cfg_div=4 mid-high-phase: cfg_ready drops, current period completes 8 cycles, then periods are 4 cycles and active_div=4 at the rise; cfg_ready returns to 1.
3. Offer cfg_div=5 and cfg_div=0: cfg_err pulses once each, active_div unchanged. With CLK_DIV_ODD_EN, cfg_div=5 is instead accepted and gives 3 high/2 low.
4. Drop run during a high phase: the high phase and full low phase finish, no further tick, clk_out stays 0, busy=0.
5. Assert cfg_valid and run=1 in the same IDLE cycle with cfg_div=6: the first period is 6 cycles.
6. Pulse rstn=0 during PEND with 4 pending: clk_out=0 next cycle, active_div=8, state IDLE, and the pending ratio is never applied.
